// File: rtl/eth_arb_pkg.sv
// Shared types and helpers for the Ethernet transmit frame arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, XFER, GAP)
//   MAX_PORTS   : upper bound on the number of source ports
//   rr_select   : round-robin pick of the first requester at or after ptr
package eth_arb_pkg;

  localparam int MAX_PORTS = 8;
  localparam int PTR_W     = $clog2(MAX_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // valid must be zero above the real port count. The scan then covers
  // every offset 0..MAX_PORTS-1 from ptr, and walking downward makes the
  // smallest offset the one that sticks.
  function automatic logic [PTR_W-1:0] rr_select(input logic [MAX_PORTS-1:0] valid,
                                                 input logic [PTR_W-1:0]     ptr);
    logic [PTR_W-1:0] idx;
    rr_select = ptr;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (valid[idx]) rr_select = idx;
    end
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer for a byte-wide AXI-Stream (data + last).
// Handshake: a beat moves on an interface in every cycle where tvalid and
// tready are both high at the rising clock edge. Once tvalid is raised, the
// sender holds it and the payload until that edge.
//   clock, aresetn           : clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast : upstream beat; s_tready is a flop output
//   m_tdata/m_tvalid/m_tlast : registered downstream beat; m_tready in
module axis_reg_slice (
  input  logic       clock,
  input  logic       aresetn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast
);

  logic       skid_valid;
  logic [7:0] skid_data;
  logic       skid_last;
  logic       in_fire;

  // Ready depends only on the skid flop, so m_tready never reaches s_tready.
  assign s_tready = !skid_valid;
  assign in_fire  = s_tvalid && !skid_valid;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (!m_tvalid || m_tready) begin
      // Output register is free or draining this cycle.
      if (skid_valid) begin
        m_tdata    <= skid_data;
        m_tlast    <= skid_last;
        m_tvalid   <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        m_tvalid <= in_fire;
        if (in_fire) begin
          m_tdata <= s_tdata;
          m_tlast <= s_tlast;
        end
      end
    end else if (in_fire) begin
      // Output stalled: park the beat that was already in flight.
      skid_data  <= s_tdata;
      skid_last  <= s_tlast;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the RMII MAC transmit stream.
// One source is granted per frame and keeps the grant until its tlast beat
// is accepted. An optional idle gap follows each frame, and the merged
// stream leaves through a registered skid buffer.
//   clock, aresetn      : RMII reference clock, asynchronous active-low reset
//   s_tdata/s_tvalid/
//   s_tready/s_tlast    : per-source byte streams, packed by port index
//   m_tdata/m_tvalid/
//   m_tready/m_tlast    : merged stream to the MAC
//   grant               : index of the current or last granted source
//   busy                : high while in XFER or GAP
//   frame_count         : completed frames, wraps at 16 bits
//   dbg_state           : current FSM state
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int IFG_CYCLES = 0
) (
  input  logic                         clock,
  input  logic                         aresetn,
  input  logic [NUM_PORTS*8-1:0]       s_tdata,
  input  logic [NUM_PORTS-1:0]         s_tvalid,
  output logic [NUM_PORTS-1:0]         s_tready,
  input  logic [NUM_PORTS-1:0]         s_tlast,
  output logic [7:0]                   m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic [$clog2(NUM_PORTS)-1:0] grant,
  output logic                         busy,
  output logic [15:0]                  frame_count,
  output arb_state_t                   dbg_state
);

  localparam int GW = $clog2(NUM_PORTS);

  arb_state_t       state, state_nxt;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    rr_ptr;
  logic [15:0]      gap_cnt;
  logic [15:0]      frame_cnt;
  logic             busy_q;
  logic [PTR_W-1:0] sel;

  logic       sl_in_valid;
  logic       sl_in_ready;
  logic       sl_in_last;
  logic [7:0] sl_in_data;
  logic       beat_fire;
  logic       last_fire;

  assign sel        = rr_select(MAX_PORTS'(s_tvalid), PTR_W'(rr_ptr));
  assign sl_in_data = s_tdata[{grant_q, 3'b000} +: 8];
  assign sl_in_last = s_tlast[grant_q];
  assign beat_fire  = sl_in_valid && sl_in_ready;
  assign last_fire  = beat_fire && sl_in_last;

  // State register.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|s_tvalid) state_nxt = XFER;
      XFER:    if (last_fire) state_nxt = (IFG_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: only the granted source sees the slice's ready, and only in
  // XFER; other sources hold their beats until their own grant.
  always_comb begin
    s_tready    = '0;
    sl_in_valid = 1'b0;
    if (state == XFER) begin
      s_tready[grant_q] = sl_in_ready;
      sl_in_valid       = s_tvalid[grant_q];
    end
  end

  // Grant, round-robin pointer, gap counter, frame counter and busy.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      grant_q   <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      if (state == IDLE && |s_tvalid) grant_q <= GW'(sel);
      if (last_fire) begin
        rr_ptr    <= (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end
      // Loading IFG-1 and leaving after zero gives exactly IFG gap cycles.
      if (state == XFER && state_nxt == GAP) gap_cnt <= 16'(IFG_CYCLES - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_count = frame_cnt;
  assign dbg_state   = state;

  axis_reg_slice u_slice (
    .clock    (clock),
    .aresetn  (aresetn),
    .s_tdata  (sl_in_data),
    .s_tvalid (sl_in_valid),
    .s_tready (sl_in_ready),
    .s_tlast  (sl_in_last),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter. Instance u_dut has no inter-frame gap and
// instance u_ifg uses a 12-cycle gap. Expected output beats {tlast, tdata}
// are queued in exp_q in the order the arbiter must emit them. A negedge
// monitor pops and compares every beat accepted by the MAC side and checks
// that the payload stays put while stalled.
module tb_eth_tx_frame_arbiter;
  import eth_arb_pkg::*;

  localparam int NP    = 2;
  localparam int IFG_B = 12;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic aresetn;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NP*8-1:0] a_s_tdata, b_s_tdata;
  logic [NP-1:0]   a_s_tvalid, b_s_tvalid, a_s_tready, b_s_tready, a_s_tlast, b_s_tlast;
  logic [7:0]      a_m_tdata, b_m_tdata;
  logic            a_m_tvalid, b_m_tvalid, a_m_tready, b_m_tready, a_m_tlast, b_m_tlast;
  logic [0:0]      a_grant, b_grant;
  logic            a_busy, b_busy;
  logic [15:0]     a_frame_count, b_frame_count;
  arb_state_t      a_dbg_state, b_dbg_state;

  logic [7:0] drv_data  [2][NP];
  logic       drv_valid [2][NP];
  logic       drv_last  [2][NP];

  assign a_s_tdata  = {drv_data[0][1], drv_data[0][0]};
  assign a_s_tvalid = {drv_valid[0][1], drv_valid[0][0]};
  assign a_s_tlast  = {drv_last[0][1], drv_last[0][0]};
  assign b_s_tdata  = {drv_data[1][1], drv_data[1][0]};
  assign b_s_tvalid = {drv_valid[1][1], drv_valid[1][0]};
  assign b_s_tlast  = {drv_last[1][1], drv_last[1][0]};

  eth_tx_frame_arbiter #(.NUM_PORTS(NP), .IFG_CYCLES(0)) u_dut (
    .clock(clock), .aresetn(aresetn),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast),
    .grant(a_grant), .busy(a_busy), .frame_count(a_frame_count), .dbg_state(a_dbg_state)
  );

  eth_tx_frame_arbiter #(.NUM_PORTS(NP), .IFG_CYCLES(IFG_B)) u_ifg (
    .clock(clock), .aresetn(aresetn),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
    .grant(b_grant), .busy(b_busy), .frame_count(b_frame_count), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic [8:0] cap_b[$];
  int         beat_cyc[$];
  int         cyc_b[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic       rdy_rand = 1'b0;
  logic       a_stall_prev = 1'b0;
  logic [8:0] a_hold = '0;

  function automatic logic [7:0] frame_byte(input int p, input int f, input int i);
    return 8'(p * 97 + f * 31 + i * 7 + (i >> 4));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- MAC-side ready ----------------
  initial begin
    a_m_tready = 1'b1;
    b_m_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      a_m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- output monitors ----------------
  always @(negedge clock) begin
    if (aresetn && mon_en) begin
      if (a_stall_prev) begin
        n_vec++;
        assert ({a_m_tvalid, a_m_tlast, a_m_tdata} === {1'b1, a_hold}) else begin
          n_err++;
          $error("FAIL stall_hold got=%h exp=%h", {a_m_tvalid, a_m_tlast, a_m_tdata}, {1'b1, a_hold});
        end
      end
      if (a_m_tvalid && a_m_tready) begin
        n_vec++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL extra_beat got=%h exp=none", {a_m_tlast, a_m_tdata});
        end
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          n_vec++;
          assert ({a_m_tlast, a_m_tdata} === e) else begin
            n_err++;
            $error("FAIL beat got=%h exp=%h", {a_m_tlast, a_m_tdata}, e);
          end
        end
        beat_cyc.push_back(cyc);
      end
      a_stall_prev = a_m_tvalid && !a_m_tready;
      a_hold       = {a_m_tlast, a_m_tdata};
    end else begin
      a_stall_prev = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (aresetn && b_m_tvalid && b_m_tready) begin
      cap_b.push_back({b_m_tlast, b_m_tdata});
      cyc_b.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int p, input int f, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), frame_byte(p, f, i)});
  endtask

  // Drives one frame on source p of instance d. When hold_at >= 0 the source
  // drops tvalid before beat hold_at for hold_len cycles.
  task automatic send_frame(input int d, input int p, input int f, input int len,
                            input int hold_at, input int hold_len);
    for (int i = 0; i < len; i++) begin
      int   budget;
      logic ok;
      logic other;
      if (i == hold_at) begin
        drv_valid[d][p] = 1'b0;
        for (int h = 0; h < hold_len; h++) begin
          @(negedge clock);
          other = (d == 0) ? a_s_tready[1 - p] : b_s_tready[1 - p];
          chk("hold_other_tready", 32'(other), 32'd0);
          @(posedge clock);
        end
        #1;
      end
      drv_data[d][p]  = frame_byte(p, f, i);
      drv_last[d][p]  = (i == len - 1);
      drv_valid[d][p] = 1'b1;
      budget = 0;
      ok     = 1'b0;
      while (!ok && budget < 5000) begin
        @(negedge clock);
        ok    = (d == 0) ? a_s_tready[p] : b_s_tready[p];
        other = (d == 0) ? a_s_tready[1 - p] : b_s_tready[1 - p];
        if (ok) chk("other_tready", 32'(other), 32'd0);
        @(posedge clock);
        #1;
        budget++;
      end
      if (!ok) begin
        chk("beat_timeout", 32'(ok), 32'd1);
        break;
      end
    end
    drv_valid[d][p] = 1'b0;
    drv_last[d][p]  = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 20000) begin
      @(posedge clock);
      b++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_tvalid"}, 32'(a_m_tvalid), 32'd0);
    chk({tag, "_m_tlast"}, 32'(a_m_tlast), 32'd0);
    chk({tag, "_m_tdata"}, 32'(a_m_tdata), 32'd0);
    chk({tag, "_s_tready"}, 32'(a_s_tready), 32'd0);
    chk({tag, "_grant"}, 32'(a_grant), 32'd0);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_frame_count"}, 32'(a_frame_count), 32'd0);
    chk({tag, "_state"}, 32'(a_dbg_state), 32'(IDLE));
    chk({tag, "_b_outs"}, {16'(b_frame_count), 8'(b_m_tdata), 2'(b_s_tready), b_m_tvalid,
                           b_m_tlast, b_grant, b_busy, 2'(b_dbg_state)}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fc;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++) begin
        drv_data[d][p]  = '0;
        drv_valid[d][p] = 1'b0;
        drv_last[d][p]  = 1'b0;
      end
    aresetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset("por");
    @(negedge clock);
    aresetn = 1'b1;
    mon_en  = 1'b1;
    fc      = 0;

    // Single source 0, 64-byte frame, contiguous output.
    beat_cyc.delete();
    push_frame(0, 0, 64);
    fork
      send_frame(0, 0, 0, 64, -1, 0);
      begin
        @(posedge clock);
        #2;
        chk("t1_grant", 32'(a_grant), 32'd0);
        chk("t1_busy", 32'(a_busy), 32'd1);
      end
    join
    wait_drain();
    fc++;
    chk("t1_frame_count", 32'(a_frame_count), 32'(fc));
    chk("t1_beats", 32'(beat_cyc.size()), 32'd64);
    if (beat_cyc.size() == 64) chk("t1_contig", 32'(beat_cyc[63] - beat_cyc[0]), 32'd63);
    chk("t1_idle_busy", 32'(a_busy), 32'd0);

    // Source 1 alone; moves the round-robin pointer back to 0.
    push_frame(1, 1, 10);
    fork
      send_frame(0, 1, 1, 10, -1, 0);
      begin
        @(posedge clock);
        #2;
        chk("t2_grant", 32'(a_grant), 32'd1);
      end
    join
    wait_drain();
    fc++;
    chk("t2_frame_count", 32'(a_frame_count), 32'(fc));

    // Both sources request together: source 0 first, one idle cycle, source 1.
    beat_cyc.delete();
    push_frame(0, 2, 12);
    push_frame(1, 3, 9);
    fork
      send_frame(0, 0, 2, 12, -1, 0);
      send_frame(0, 1, 3, 9, -1, 0);
    join
    wait_drain();
    fc += 2;
    chk("t3_frame_count", 32'(a_frame_count), 32'(fc));
    chk("t3_beats", 32'(beat_cyc.size()), 32'd21);
    if (beat_cyc.size() == 21) begin
      chk("t3_contig0", 32'(beat_cyc[11] - beat_cyc[0]), 32'd11);
      chk("t3_gap", 32'(beat_cyc[12] - beat_cyc[11]), 32'd2);
    end
    chk("t3_grant", 32'(a_grant), 32'd1);

    // Source 1 stalls 20 cycles mid-frame while source 0 waits.
    push_frame(1, 4, 30);
    push_frame(0, 5, 8);
    fork
      send_frame(0, 1, 4, 30, 10, 20);
      begin
        repeat (3) @(posedge clock);
        #1;
        send_frame(0, 0, 5, 8, -1, 0);
      end
    join
    wait_drain();
    fc += 2;
    chk("t4_frame_count", 32'(a_frame_count), 32'(fc));
    chk("t4_grant", 32'(a_grant), 32'd0);

    // Random MAC backpressure, random sources, lengths incl. 1 and 1518.
    rdy_rand = 1'b1;
    for (int k = 0; k < 32; k++) begin
      int p;
      int len;
      p   = $urandom_range(0, 1);
      len = (k == 0) ? 1 : (k == 1) ? 1518 : $urandom_range(1, 80);
      push_frame(p, 10 + k, len);
      send_frame(0, p, 10 + k, len, -1, 0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    wait_drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    fc += 32;
    chk("t5_frame_count", 32'(a_frame_count), 32'(fc));

    // 12-cycle inter-frame gap on the second instance.
    send_frame(1, 0, 6, 5, -1, 0);
    chk("t6_gap_busy", 32'(b_busy), 32'd1);
    chk("t6_gap_state", 32'(b_dbg_state), 32'(GAP));
    chk("t6_gap_tready", 32'(b_s_tready), 32'd0);
    send_frame(1, 0, 7, 4, -1, 0);
    repeat (4) @(posedge clock);
    #1;
    chk("t6_beats", 32'(cap_b.size()), 32'd9);
    if (cap_b.size() == 9) begin
      for (int j = 0; j < 9; j++) begin
        logic [8:0] e;
        e = (j < 5) ? {(j == 4), frame_byte(0, 6, j)} : {(j == 8), frame_byte(0, 7, j - 5)};
        chk("t6_data", 32'(cap_b[j]), 32'(e));
      end
      chk("t6_ifg", 32'(cyc_b[5] - cyc_b[4]), 32'(IFG_B + 2));
    end
    chk("t6_frame_count", 32'(b_frame_count), 32'd2);

    // Asynchronous reset in the middle of a frame from source 1.
    mon_en = 1'b0;
    drv_data[0][1]  = 8'h5A;
    drv_last[0][1]  = 1'b0;
    drv_valid[0][1] = 1'b1;
    repeat (8) @(posedge clock);
    #3;
    aresetn = 1'b0;
    #1;
    check_reset("mid");
    drv_valid[0][1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    aresetn = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    push_frame(1, 50, 16);
    fork
      send_frame(0, 1, 50, 16, -1, 0);
      begin
        repeat (6) @(posedge clock);
        #2;
        chk("t7_fc_mid", 32'(a_frame_count), 32'd0);
        chk("t7_grant", 32'(a_grant), 32'd1);
      end
    join
    wait_drain();
    chk("t7_frame_count", 32'(a_frame_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

endmodule
